alu_srcb_stage: RTL
===================

Name: alu_srcb_stage

Overview:
Registered, parametrised successor to the ALU operand-B selector in the multicycle datapath. It selects operand B from 8 encoded sources: register B, increment constant, immediate variants and the register-2 fast-track (forwarded) value. The selected value is held in an output register behind a valid/ready handshake. When the fast-track value is not yet available, the stage stalls until it arrives. It sits between the register-file/immediate-extend logic and the ALU input register.

Parameters:
DATA_WIDTH, 32, width of all data operands and out_b
IMM_WIDTH, 16, width of raw immediate; legal range 1..DATA_WIDTH
INC_VALUE, 1, constant driven for select 3'b001 (truncated to DATA_WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  request carries a valid select/operand set
in_ready  output  1  stage accepts request this cycle
alu_src_b  input  3  source select, sampled on accept
data_reg_b  input  DATA_WIDTH  register-B value
imm  input  IMM_WIDTH  raw immediate field
fwd_data  input  DATA_WIDTH  register-2 fast-track value
fwd_valid  input  1  fwd_data is valid this cycle
out_valid  output  1  out_b holds a valid operand
out_ready  input  1  consumer takes out_b this cycle
out_b  output  DATA_WIDTH  registered operand B
out_sel_err  output  1  registered; set with an operand produced from select 3'b111
stat_ops  output  32  accepted-request counter (see Optional Feature)
stat_fwd_wait  output  32  fast-track wait-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=RUN; out_valid=0, out_b=0, out_sel_err=0, stats=0; in_ready follows its equation (state RUN, out_valid 0 -> 1 once rst released).
- Select decode (SE=sign-extend imm to DATA_WIDTH, ZE=zero-extend):
  - 000: data_reg_b.
  - 001: INC_VALUE.
  - 010: SE.
  - 011: fast-track fwd_data.
  - 100: ZE.
  - 101: SE<<2, truncated to DATA_WIDTH.
  - 110: imm in upper IMM_WIDTH bits, lower DATA_WIDTH-IMM_WIDTH bits zero.
  - 111: all ones, out_sel_err=1.
  - out_sel_err=0 for every other select.
- States: RUN, WAIT_FWD.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Accept with select!=011, or select==011 with fwd_valid=1:
  - next edge: out_b=decoded value, out_valid=1, out_sel_err set per decode.
  - Latency 1 cycle; throughput 1 per cycle when out_ready held high.
- Accept with select==011 and fwd_valid=0:
  - next edge: state=WAIT_FWD, out_valid=0.
  - No request fields are stored; the result comes from fwd_data only.
- WAIT_FWD:
  - in_ready=0.
  - Each cycle with fwd_valid=1 -> next edge out_b=fwd_data, out_valid=1, out_sel_err=0, state=RUN.
  - fwd_valid is ignored in RUN except in an accept cycle.
- Output hold:
  - out_valid && !out_ready -> out_b, out_sel_err held stable.
  - out_valid drops to 0 on the edge after out_ready=1 if no new result is loaded.
- Simultaneous drain and load: out_valid=1, out_ready=1, accept in the same cycle -> new value loaded, out_valid stays 1, no bubble.
- Reset mid-WAIT_FWD: pending operation discarded; state=RUN, out_valid=0.
- Inputs are sampled only on accept or in WAIT_FWD; changes at other times have no effect.

Optional Feature:
Macro SRCB_STATS_EN.
- Defined:
  - stat_ops increments by 1 on every accept.
  - stat_fwd_wait increments by 1 for every clock cycle spent in state WAIT_FWD, including the cycle fwd_valid arrives.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: stat_ops and stat_fwd_wait tied to 0, no counter flops synthesised; all other behaviour identical.

Test Plan:
1. Reset, then per request below: out_ready=1, one accept, check out_b after 1 cycle. All 8 selects, imm=16'hFFF0, data_reg_b=32'h12345678, fwd_valid=1, fwd_data=32'hCAFEBABE -> out_b in select order:
   - 12345678, 00000001, FFFFFFF0, CAFEBABE, 0000FFF0, FFFFFFC0, FFF00000, FFFFFFFF.
   - out_sel_err=1 only for 111.
2. Select 011 with fwd_valid=0 for 3 cycles, then fwd_valid=1, fwd_data=32'h0000BEEF:
   - in_ready=0 during wait.
   - out_valid=1, out_b=0000BEEF on the edge after fwd_valid.
   - With SRCB_STATS_EN: stat_fwd_wait=4, stat_ops=1.
3. Back-to-back selects 000/010/001 with out_ready=1 -> out_valid stays 1 for 3 consecutive cycles, in_ready never drops, values in order.
4. out_ready=0 with result 32'h12345678 held, new in_valid=1 -> in_ready=0, out_b stable 5 cycles. Then out_ready=1 -> next request accepted same cycle.
5. rst pulsed asynchronously (mid-cycle) while in WAIT_FWD -> out_valid=0 immediately, state RUN, counters 0. A later fwd_valid=1 produces no output.
6. Counter wrap: force stat_ops to 32'hFFFFFFFF with SRCB_STATS_EN, one accept -> 0. Without macro both stats read 0 throughout tests 1-5.

Source files
------------

// File: rtl/alu_srcb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_srcb_if
// Description : Bundles the operand-B stage request, fast-track, result and
//               statistics signals. The master side is the upstream driver
//               plus ALU consumer; the slave side is the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_srcb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            alu_src_b;
    logic [DATA_WIDTH-1:0] data_reg_b;
    logic [IMM_WIDTH-1:0]  imm;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_sel_err;
    logic [31:0]           stat_ops;
    logic [31:0]           stat_fwd_wait;

    modport master (
        output in_valid, alu_src_b, data_reg_b, imm, fwd_data, fwd_valid, out_ready,
        input  in_ready, out_valid, out_b, out_sel_err, stat_ops, stat_fwd_wait
    );

    modport slave (
        input  in_valid, alu_src_b, data_reg_b, imm, fwd_data, fwd_valid, out_ready,
        output in_ready, out_valid, out_b, out_sel_err, stat_ops, stat_fwd_wait
    );
endinterface
`default_nettype wire

// File: rtl/alu_srcb_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_srcb_stage
// Description : Registered ALU operand-B selector. Decodes one of eight
//               sources into an output register behind a valid/ready
//               handshake and stalls on the register-2 fast-track value
//               until it becomes valid.
//               Optional macro SRCB_STATS_EN enables the accepted-request
//               and fast-track wait-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_srcb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int INC_VALUE  = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_srcb_if.slave   bus
);

    localparam logic [DATA_WIDTH-1:0] c_INC    = DATA_WIDTH'(INC_VALUE);
    localparam logic [2:0]            c_SEL_FWD = 3'b011;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        WAIT_FWD = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_outValid;
    logic [DATA_WIDTH-1:0] r_outB;
    logic                  r_selErr;

    logic [DATA_WIDTH-1:0] w_immSe;
    logic [DATA_WIDTH-1:0] w_immZe;
    logic [DATA_WIDTH-1:0] w_decoded;
    logic                  w_selErr;
    logic                  w_inReady;
    logic                  w_accept;
    logic                  w_fwdStall;

    assign w_immSe = DATA_WIDTH'($signed(bus.imm));
    assign w_immZe = DATA_WIDTH'(bus.imm);

    // Decode the selected operand-B source from the current request fields
    always_comb begin
        w_decoded = '0;
        w_selErr  = 1'b0;
        case (bus.alu_src_b)
            3'b000:  w_decoded = bus.data_reg_b;
            3'b001:  w_decoded = c_INC;
            3'b010:  w_decoded = w_immSe;
            3'b011:  w_decoded = bus.fwd_data;
            3'b100:  w_decoded = w_immZe;
            3'b101:  w_decoded = w_immSe << 2;
            3'b110:  w_decoded = w_immZe << (DATA_WIDTH - IMM_WIDTH);
            3'b111: begin
                w_decoded = '1;
                w_selErr  = 1'b1;
            end
            default: w_decoded = '0;
        endcase
    end

    assign w_inReady  = (r_state == RUN) && (!r_outValid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_inReady;
    // A fast-track request whose value is not yet present parks the stage
    assign w_fwdStall = (bus.alu_src_b == c_SEL_FWD) && !bus.fwd_valid;

    // Control FSM and output register: load on accept or fast-track arrival, drain on out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_outValid <= 1'b0;
            r_outB     <= '0;
            r_selErr   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        if (w_fwdStall) begin
                            r_state    <= WAIT_FWD;
                            r_outValid <= 1'b0;
                        end else begin
                            r_outB     <= w_decoded;
                            r_outValid <= 1'b1;
                            r_selErr   <= w_selErr;
                        end
                    end else if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                WAIT_FWD: begin
                    if (bus.fwd_valid) begin
                        r_outB     <= bus.fwd_data;
                        r_outValid <= 1'b1;
                        r_selErr   <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = r_outValid;
    assign bus.out_b       = r_outB;
    assign bus.out_sel_err = r_selErr;

`ifdef SRCB_STATS_EN
    logic [31:0] r_statOps;
    logic [31:0] r_statFwdWait;

    // Count accepted requests and every cycle spent parked on the fast-track value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statOps     <= '0;
            r_statFwdWait <= '0;
        end else begin
            if (w_accept) begin
                r_statOps <= r_statOps + 32'd1;
            end
            if (r_state == WAIT_FWD) begin
                r_statFwdWait <= r_statFwdWait + 32'd1;
            end
        end
    end

    assign bus.stat_ops      = r_statOps;
    assign bus.stat_fwd_wait = r_statFwdWait;
`else
    assign bus.stat_ops      = 32'd0;
    assign bus.stat_fwd_wait = 32'd0;
`endif

endmodule
`default_nettype wire
